// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants and helpers: the hex glyph table (active-low form),
// the blank pattern and the index-width helper used by the scan driver and static displays.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Glyphs 0-9, A, b, C, d, E, F as {g,f,e,d,c,b,a}, a lit segment reads 0
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle between the datapath and the scan driver: data/control in, pin drive out.
interface seven_seg_scan_if #(
   parameter int NUM_DIGITS = 4
);

   logic                      en;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     dp;
   logic                      load;
   logic                      blank_lz;
   logic [6:0]                seg;
   logic                      dp_out;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_done;

   modport master (
      output en, value, dp, load, blank_lz,
      input  seg, dp_out, an, frame_done
   );

   modport slave (
      input  en, value, dp, load, blank_lz,
      output seg, dp_out, an, frame_done
   );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational nibble-to-glyph decoder, active-low segments; shared with static single-digit displays.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a bank of common-anode digits: one digit per prescaler slot,
// double-buffered value so a frame never mixes old and new digits, dead time against ghosting.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SCAN_DIV    = 50000,
   parameter int DEAD_CYC    = 2,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input logic             clk,
   input logic             rst_n,
   seven_seg_scan_if.slave bus
);

   localparam int IW = idx_width(NUM_DIGITS);
   localparam int PW = idx_width(SCAN_DIV);
   localparam int VW = 4 * NUM_DIGITS;

   localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? SEG_BLANK : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;

   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic [VW-1:0]         pend_val;
   logic [VW-1:0]         disp_val;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic [NUM_DIGITS-1:0] disp_dp;

   logic                  slot_end;
   logic                  last_digit;
   logic                  frame_wrap;
   logic                  in_dead;
   logic [VW-1:0]         upper_val;
   logic [3:0]            cur_nib;
   logic                  digit_blank;
   logic [6:0]            cur_seg;
   logic [NUM_DIGITS-1:0] an_onehot;

   logic [6:0]            seg_next;
   logic                  dp_next;
   logic [NUM_DIGITS-1:0] an_next;

   logic [6:0]            seg_q;
   logic                  dp_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  frame_done_q;

   // Slot/frame boundaries and the digit currently owning the bus
   always_comb begin
      slot_end    = (presc == PW'(SCAN_DIV - 1));
      last_digit  = (idx == IW'(NUM_DIGITS - 1));
      frame_wrap  = bus.en && slot_end && last_digit;
      in_dead     = (presc < PW'(DEAD_CYC));
      upper_val   = disp_val >> {idx, 2'b00};
      cur_nib     = upper_val[3:0];
      digit_blank = bus.blank_lz && (idx != '0) && (upper_val == '0);
      an_onehot   = NUM_DIGITS'(1) << idx;
   end

   seven_seg_decode u_decode (
      .nibble (cur_nib),
      .blank  (digit_blank),
      .seg    (cur_seg)
   );

   // Segments keep the current glyph through the dead time; only the anodes go dark
   always_comb begin
      seg_next = SEG_OFF;
      dp_next  = DP_OFF;
      an_next  = AN_OFF;
      if (bus.en) begin
         seg_next = (SEG_ACT_LOW != 0) ? cur_seg : ~cur_seg;
         dp_next  = (SEG_ACT_LOW != 0) ? ~disp_dp[idx] : disp_dp[idx];
         if (!in_dead) begin
            an_next = (AN_ACT_LOW != 0) ? ~an_onehot : an_onehot;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (bus.en) begin
         if (slot_end) begin
            presc <= '0;
            idx   <= last_digit ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Display takes the old pending on the wrap edge, so a load on that same edge waits a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val <= '0;
         pend_dp  <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
      end else begin
         if (bus.load) begin
            pend_val <= bus.value;
            pend_dp  <= bus.dp;
         end
         if (frame_wrap) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         an_q         <= AN_OFF;
         frame_done_q <= 1'b0;
      end else begin
         seg_q        <= seg_next;
         dp_q         <= dp_next;
         an_q         <= an_next;
         frame_done_q <= frame_wrap;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp_out     = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random traffic, all checked against a
// cycle-count reference model of the scan (slot/digit derived by division of enabled cycles).
module tb_seven_seg_scan;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int DEAD  = 1;
   localparam int FRAME = N * DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

   seven_seg_scan #(
      .NUM_DIGITS  (N),
      .SCAN_DIV    (DIV),
      .DEAD_CYC    (DEAD),
      .SEG_ACT_LOW (1),
      .AN_ACT_LOW  (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int n_compared = 0;
   int n_mismatched = 0;

   // Reference model: enabled cycles since reset, pending and displayed data
   int          act;
   logic [15:0] m_pend, m_disp;
   logic [3:0]  m_pdp, m_ddp;

   logic [15:0] cur_value;
   logic [3:0]  cur_dp;
   logic        cur_blz;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      act    = 0;
      m_pend = '0;
      m_disp = '0;
      m_pdp  = '0;
      m_ddp  = '0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_an"}, 32'(bus.an), 32'h0F);
      checkOutput({tag, "_seg"}, 32'(bus.seg), 32'h7F);
      checkOutput({tag, "_dp"}, 32'(bus.dp_out), 32'h1);
      checkOutput({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
   endtask

   // One clock: predict the registered outputs from the pre-edge model, advance, compare at negedge
   task automatic runCycle();
      int         phase, digit;
      logic [3:0] nib;
      logic [6:0] exp_seg;
      logic       exp_dp, exp_fd, check_seg;
      logic [3:0] exp_an;
      phase = act % DIV;
      digit = (act / DIV) % N;
      nib   = m_disp[4*digit +: 4];
      if (!bus.en) begin
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0; check_seg = 1'b1;
      end else begin
         exp_fd    = ((act % FRAME) == FRAME - 1);
         check_seg = (phase >= DEAD);
         exp_an    = (phase < DEAD) ? 4'hF : ~(4'b0001 << digit);
         exp_seg   = (bus.blank_lz && digit != 0 && (m_disp >> (4*digit)) == 16'h0) ? 7'h7F : glyph[nib];
         exp_dp    = ~m_ddp[digit];
      end
      @(posedge clk);
      if (bus.en) begin
         if ((act % FRAME) == FRAME - 1) begin
            m_disp = m_pend;
            m_ddp  = m_pdp;
         end
         act++;
      end
      if (bus.load) begin
         m_pend = bus.value;
         m_pdp  = bus.dp;
      end
      @(negedge clk);
      checkOutput("an", 32'(bus.an), 32'(exp_an));
      checkOutput("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      checkOutput("an_onehot", 32'($countones(~bus.an) <= 1), 32'h1);
      if (check_seg) begin
         checkOutput("seg", 32'(bus.seg), 32'(exp_seg));
         checkOutput("dp_out", 32'(bus.dp_out), 32'(exp_dp));
      end
   endtask

   task automatic applyStimulus(input logic e, input logic ld, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         bus.en       = e;
         bus.value    = cur_value;
         bus.dp       = cur_dp;
         bus.load     = (i == 0) ? ld : 1'b0;
         bus.blank_lz = cur_blz;
         runCycle();
      end
   endtask

   initial begin
      bus.en = 1'b0; bus.value = '0; bus.dp = '0; bus.load = 1'b0; bus.blank_lz = 1'b0;
      cur_value = '0; cur_dp = '0; cur_blz = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;

      // Basic scan of 12AF with the dp on digit 2
      cur_value = 16'h12AF; cur_dp = 4'b0100;
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 3 * FRAME);

      // Leading-zero blanking on and off, then an all-zero value
      cur_value = 16'h0005; cur_dp = 4'b0000; cur_blz = 1'b1;
      applyStimulus(1'b1, 1'b1, 2 * FRAME + 3);
      cur_blz = 1'b0;
      applyStimulus(1'b1, 1'b0, FRAME);
      cur_value = 16'h0000; cur_blz = 1'b1;
      applyStimulus(1'b1, 1'b1, 2 * FRAME);

      // Mid-frame load, then a load landing exactly on the wrap cycle
      applyStimulus(1'b1, 1'b0, 5);
      cur_value = 16'h1111; cur_dp = 4'b1001;
      applyStimulus(1'b1, 1'b1, 2 * FRAME);
      while ((act % FRAME) != FRAME - 1) applyStimulus(1'b1, 1'b0, 1);
      cur_value = 16'h2222; cur_dp = 4'b0010;
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 2 * FRAME + 1);

      // Scan pause mid-slot with a load while dark
      while ((act % DIV) != 2) applyStimulus(1'b1, 1'b0, 1);
      cur_value = 16'h3C4D;
      applyStimulus(1'b0, 1'b1, 10);
      applyStimulus(1'b1, 1'b0, 2 * FRAME);

      // Asynchronous reset between clock edges
      while ((act % DIV) != 2) applyStimulus(1'b1, 1'b0, 1);
      #2 rst_n = 1'b0;
      #1 checkResetState("async_reset");
      @(negedge clk);
      modelReset();
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, FRAME + 4);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0)
            cur_value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         cur_dp = 4'($urandom);
         if ($urandom_range(0, 29) == 0) cur_blz = ~cur_blz;
         applyStimulus(($urandom_range(0, 14) != 0), ($urandom_range(0, 7) == 0), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
